fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall control, IF/ID pipeline
// register, misaligned-redirect capture and fetch/flush performance counters.

package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallF,
  input  logic        i_stallD,
  input  logic        i_flushD,
  input  logic        i_br_sel,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_pcD,
  output logic [31:0] o_pc4D,
  output logic [31:0] o_instrD,
  output logic        o_validD,
  output logic        o_misalign,
  output logic [31:0] o_bad_addr,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic [XLEN-1:0] pc_plus4;
  logic            capture;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign capture  = !i_flushD && !i_stallD;

  // Next-state: redirect beats stall for the PC; flush beats stall for IF/ID.
  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    misalign_d  = misalign_q;
    bad_addr_d  = bad_addr_q;

    if (i_br_sel) begin
      pc_d = {i_br_target[31:1], 1'b0};
    end else if (!i_stallF) begin
      pc_d = pc_plus4;
    end

    if (i_flushD) begin
      ifid_d      = IFID_BUBBLE;
      flush_cnt_d = flush_cnt_q + XLEN'(1);
    end else if (capture) begin
      ifid_d.pc    = pc_q;
      ifid_d.pc4   = pc_plus4;
      ifid_d.instr = i_imem_rdata;
      ifid_d.valid = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + XLEN'(1);
    end

    // Only the first misaligned target is kept for diagnosis.
    if (i_br_sel && i_br_target[1] && !misalign_q) begin
      misalign_d = 1'b1;
      bad_addr_d = i_br_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q        <= RESET_PC;
      ifid_q      <= IFID_BUBBLE;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_pcD       = ifid_q.pc;
  assign o_pc4D      = ifid_q.pc4;
  assign o_instrD    = ifid_q.instr;
  assign o_validD    = ifid_q.valid;
  assign o_misalign  = misalign_q;
  assign o_bad_addr  = bad_addr_q;
  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected states are queued as each step is
// driven and popped for comparison after the following clock edge.

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcD;
    logic [31:0] pc4D;
    logic [31:0] instrD;
    logic        validD;
    logic [31:0] fcnt;
    logic [31:0] flcnt;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stallF;
  logic        i_stallD;
  logic        i_flushD;
  logic        i_br_sel;
  logic [31:0] i_br_target;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_imem_addr;
  logic [31:0] o_pcD;
  logic [31:0] o_pc4D;
  logic [31:0] o_instrD;
  logic        o_validD;
  logic        o_misalign;
  logic [31:0] o_bad_addr;
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_flush_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fetch_stage dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stallF    (i_stallF),
    .i_stallD    (i_stallD),
    .i_flushD    (i_flushD),
    .i_br_sel    (i_br_sel),
    .i_br_target (i_br_target),
    .i_imem_rdata(i_imem_rdata),
    .o_imem_addr (o_imem_addr),
    .o_pcD       (o_pcD),
    .o_pc4D      (o_pc4D),
    .o_instrD    (o_instrD),
    .o_validD    (o_validD),
    .o_misalign  (o_misalign),
    .o_bad_addr  (o_bad_addr),
    .o_fetch_cnt (o_fetch_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  // Instruction memory: a distinct word per address, returned combinationally.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign i_imem_rdata = imem(o_imem_addr);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t mk(input logic [31:0] pc, pcD, pc4D, instrD, input logic validD,
                              input logic [31:0] fcnt, flcnt, input logic mis,
                              input logic [31:0] bad_a);
    exp_t e;
    e.pc = pc; e.pcD = pcD; e.pc4D = pc4D; e.instrD = instrD; e.validD = validD;
    e.fcnt = fcnt; e.flcnt = flcnt; e.mis = mis; e.bad = bad_a;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Clock once (or not, for the asynchronous-hold check), then compare against the queue head.
  task automatic step(input bit do_clk, input string name, input exp_t e);
    exp_t g;
    sb.push_back(e);
    if (do_clk) @(posedge i_clk);
    #1;
    g = sb.pop_front();
    chk({name, ".pc"},     o_imem_addr, g.pc);
    chk({name, ".pcD"},    o_pcD,       g.pcD);
    chk({name, ".pc4D"},   o_pc4D,      g.pc4D);
    chk({name, ".instrD"}, o_instrD,    g.instrD);
    chk({name, ".validD"}, 32'(o_validD),   32'(g.validD));
    chk({name, ".fcnt"},   o_fetch_cnt, g.fcnt);
    chk({name, ".flcnt"},  o_flush_cnt, g.flcnt);
    chk({name, ".mis"},    32'(o_misalign), 32'(g.mis));
    chk({name, ".bad"},    o_bad_addr,  g.bad);
  endtask

  task automatic drive(input bit rst_n, stF, stD, flD, br, input logic [31:0] tgt);
    i_rst_n = rst_n; i_stallF = stF; i_stallD = stD; i_flushD = flD;
    i_br_sel = br; i_br_target = tgt;
  endtask

  initial begin
    // Reset overrides a simultaneous redirect, flush and stall.
    drive(0, 1, 1, 1, 1, 32'h0000_0502);
    step(1, "rst_busy", mk(0, 0, 0, NOP, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    step(1, "rst", mk(0, 0, 0, NOP, 0, 0, 0, 0, 0));

    // Free run
    drive(1, 0, 0, 0, 0, 0);
    step(1, "run1", mk(32'h4, 32'h0, 32'h4, imem(32'h0), 1, 1, 0, 0, 0));
    step(1, "run2", mk(32'h8, 32'h4, 32'h8, imem(32'h4), 1, 2, 0, 0, 0));

    // Full stall at PC=8 for two cycles, then release
    drive(1, 1, 1, 0, 0, 0);
    step(1, "stall1", mk(32'h8, 32'h4, 32'h8, imem(32'h4), 1, 2, 0, 0, 0));
    step(1, "stall2", mk(32'h8, 32'h4, 32'h8, imem(32'h4), 1, 2, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0);
    step(1, "resume", mk(32'hC, 32'h8, 32'hC, imem(32'h8), 1, 3, 0, 0, 0));

    // Redirect beats stallF; flush squashes IF/ID
    drive(1, 1, 0, 1, 1, 32'h0000_0100);
    step(1, "br_flush", mk(32'h100, 0, 0, NOP, 0, 3, 1, 0, 0));
    drive(1, 0, 0, 0, 0, 0);
    step(1, "after_br", mk(32'h104, 32'h100, 32'h104, imem(32'h100), 1, 4, 1, 0, 0));

    // Misaligned redirects: only the first target is captured
    drive(1, 0, 0, 0, 1, 32'h0000_0202);
    step(1, "mis1", mk(32'h202, 32'h104, 32'h108, imem(32'h104), 1, 5, 1, 1, 32'h202));
    drive(1, 0, 0, 0, 1, 32'h0000_0306);
    step(1, "mis2", mk(32'h306, 32'h202, 32'h206, imem(32'h202), 1, 6, 1, 1, 32'h202));
    drive(1, 0, 0, 0, 1, 32'h0000_0101);
    step(1, "bit0", mk(32'h100, 32'h306, 32'h30A, imem(32'h306), 1, 7, 1, 1, 32'h202));

    // Flush wins over stallD; then a stallD hold keeps the bubble
    drive(1, 0, 1, 1, 0, 0);
    step(1, "flush_stD", mk(32'h104, 0, 0, NOP, 0, 7, 2, 1, 32'h202));
    drive(1, 1, 1, 0, 0, 0);
    step(1, "hold_bub", mk(32'h104, 0, 0, NOP, 0, 7, 2, 1, 32'h202));

    // PC wrap at the top of the address space
    drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, "to_top", mk(32'hFFFF_FFFC, 32'h104, 32'h108, imem(32'h104), 1, 8, 2, 1, 32'h202));
    drive(1, 0, 0, 0, 0, 0);
    step(1, "pc_wrap", mk(32'h0, 32'hFFFF_FFFC, 32'h0, imem(32'hFFFF_FFFC), 1, 9, 2, 1, 32'h202));

    // Counter wrap: preload both counters to all-ones
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    release dut.flush_cnt_q;
    drive(1, 0, 0, 1, 0, 0);
    step(1, "flcnt_wrap", mk(32'h4, 0, 0, NOP, 0, 32'hFFFF_FFFF, 0, 1, 32'h202));
    drive(1, 0, 0, 0, 0, 0);
    step(1, "fcnt_wrap", mk(32'h8, 32'h4, 32'h8, imem(32'h4), 1, 0, 0, 1, 32'h202));

    // Reset asserted mid-cycle during a redirect: no change until the edge
    drive(0, 0, 0, 0, 1, 32'h0000_0400);
    step(0, "rst_sync", mk(32'h8, 32'h4, 32'h8, imem(32'h4), 1, 0, 0, 1, 32'h202));
    step(1, "rst_mid", mk(0, 0, 0, NOP, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
